// File: rtl/uart_tx_stim.sv
// UART frame generator: a byte FIFO feeds a frame FSM that drives a registered serial line.
// Optional parity, and per-byte parity-flip and framing-error injection.
module uart_tx_stim #(
  parameter int CLKS_PER_BIT = 3,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 2,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          io_clk,
  input  logic                          io_nreset,
  input  logic                          io_enable,
  input  logic                          io_in_valid,
  output logic                          io_in_ready,
  input  logic [DATA_BITS-1:0]          io_in_payload_data,
  input  logic                          io_in_payload_flip_parity,
  input  logic                          io_in_payload_framing_err,
  output logic                          io_tx,
  output logic                          io_busy,
  output logic [$clog2(FIFO_DEPTH):0]   io_fifo_level,
  output logic [31:0]                   io_sent_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int MAXB = (DATA_BITS > IDLE_BITS)
                        ? ((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS)
                        : ((IDLE_BITS > STOP_BITS) ? IDLE_BITS : STOP_BITS);
  localparam int BW   = $clog2(MAXB);
  localparam int EW   = DATA_BITS + 2;

  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  localparam state_t FIRST_STATE = (IDLE_BITS == 0) ? S_START : S_GAP;

  // FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          push, pop;
  logic [EW-1:0] head;

  assign io_in_ready = (level != LW'(FIFO_DEPTH));
  assign push        = io_in_valid & io_in_ready;
  assign head        = mem[rd_ptr];

  always_ff @(posedge io_clk) begin
    if (push)
      mem[wr_ptr] <= {io_in_payload_framing_err, io_in_payload_flip_parity, io_in_payload_data};
  end

  always_ff @(posedge io_clk or negedge io_nreset) begin
    if (!io_nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame FSM
  state_t                 state, state_d;
  logic [CW-1:0]          cyc_cnt, cyc_d;
  logic [BW-1:0]          bit_cnt, bit_d;
  logic [DATA_BITS-1:0]   data_q, data_sh;
  logic                   fp_q, fe_q;
  logic                   tx_q, tx_d;
  logic [31:0]            sent_q;
  logic                   bit_end, can_pop, launch, sent_inc, par_bit;

  assign bit_end = (cyc_cnt == CYC_LAST);
  assign can_pop = io_enable & (level != '0);
  assign par_bit = ((PARITY == 1) ? ~(^data_q) : (^data_q)) ^ fp_q;

  always_comb begin
    state_d  = state;
    cyc_d    = bit_end ? '0 : cyc_cnt + CW'(1);
    bit_d    = bit_cnt;
    launch   = 1'b0;
    sent_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        cyc_d  = '0;
        bit_d  = '0;
        launch = can_pop;
      end
      S_GAP: if (bit_end) begin
        if (bit_cnt == GAP_LAST) begin
          state_d = S_START;
          bit_d   = '0;
        end else begin
          bit_d = bit_cnt + BW'(1);
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (bit_end) begin
        if (bit_cnt == DATA_LAST) begin
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          bit_d   = '0;
        end else begin
          bit_d = bit_cnt + BW'(1);
        end
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: if (bit_end) begin
        if (bit_cnt == STOP_LAST) begin
          // The end of the last stop bit doubles as the IDLE decision point,
          // so queued frames follow with no dead cycle.
          sent_inc = 1'b1;
          launch   = can_pop;
          state_d  = S_IDLE;
          bit_d    = '0;
        end else begin
          bit_d = bit_cnt + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      state_d = FIRST_STATE;
      cyc_d   = '0;
      bit_d   = '0;
    end
  end

  assign pop = launch;

  // Line level is derived from the next state so io_tx comes straight from a flop.
  always_comb begin
    data_sh = data_q >> bit_d;
    tx_d    = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_sh[0];
      S_PARITY: tx_d = par_bit;
      S_STOP:   tx_d = ~(fe_q & (bit_d == '0));
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge io_clk or negedge io_nreset) begin
    if (!io_nreset) begin
      state   <= S_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      sent_q  <= '0;
      data_q  <= '0;
      fp_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state   <= state_d;
      cyc_cnt <= cyc_d;
      bit_cnt <= bit_d;
      tx_q    <= tx_d;
      if (sent_inc) sent_q <= sent_q + 32'd1;
      if (pop) {fe_q, fp_q, data_q} <= head;
    end
  end

  assign io_tx         = tx_q;
  assign io_busy       = (state != S_IDLE) | (level != '0);
  assign io_fifo_level = level;
  assign io_sent_count = sent_q;

endmodule

// File: tb/tb_uart_tx_stim.sv
// Bench for uart_tx_stim: three configurations checked cycle by cycle against
// a frame-level line model built from the bit list of each frame.
module tb_uart_tx_stim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              nrst;
  logic [2:0]        en, valid, fp, fe, ready, tx, busy;
  logic [7:0]        d0, d1;
  logic [6:0]        d2;
  logic [2:0][4:0]   level;
  logic [2:0][31:0]  sent;

  uart_tx_stim dut_a (
    .io_clk(clk), .io_nreset(nrst), .io_enable(en[0]), .io_in_valid(valid[0]),
    .io_in_ready(ready[0]), .io_in_payload_data(d0), .io_in_payload_flip_parity(fp[0]),
    .io_in_payload_framing_err(fe[0]), .io_tx(tx[0]), .io_busy(busy[0]),
    .io_fifo_level(level[0]), .io_sent_count(sent[0])
  );

  uart_tx_stim #(.PARITY(1)) dut_b (
    .io_clk(clk), .io_nreset(nrst), .io_enable(en[1]), .io_in_valid(valid[1]),
    .io_in_ready(ready[1]), .io_in_payload_data(d1), .io_in_payload_flip_parity(fp[1]),
    .io_in_payload_framing_err(fe[1]), .io_tx(tx[1]), .io_busy(busy[1]),
    .io_fifo_level(level[1]), .io_sent_count(sent[1])
  );

  uart_tx_stim #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .IDLE_BITS(0)) dut_c (
    .io_clk(clk), .io_nreset(nrst), .io_enable(en[2]), .io_in_valid(valid[2]),
    .io_in_ready(ready[2]), .io_in_payload_data(d2), .io_in_payload_flip_parity(fp[2]),
    .io_in_payload_framing_err(fe[2]), .io_tx(tx[2]), .io_busy(busy[2]),
    .io_fifo_level(level[2]), .io_sent_count(sent[2])
  );

  int cfg_cpb[3]   = '{3, 3, 4};
  int cfg_dbits[3] = '{8, 8, 7};
  int cfg_par[3]   = '{2, 1, 0};
  int cfg_stop[3]  = '{1, 1, 2};
  int cfg_idle[3]  = '{1, 1, 0};

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt[3] = '{0, 0, 0};
  bit exp_bits[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
  endtask

  // Appends the expected line level, one entry per clock, for one frame.
  function automatic void add_frame(int i, logic [7:0] d, bit f_par, bit f_frm);
    bit bits[$];
    int ones;
    ones = 0;
    for (int b = 0; b < cfg_idle[i]; b++) bits.push_back(1'b1);
    bits.push_back(1'b0);
    for (int b = 0; b < cfg_dbits[i]; b++) begin
      bits.push_back(d[b]);
      ones += int'(d[b]);
    end
    if (cfg_par[i] == 2) bits.push_back(((ones % 2) == 1) ^ f_par);
    if (cfg_par[i] == 1) bits.push_back(((ones % 2) == 0) ^ f_par);
    for (int b = 0; b < cfg_stop[i]; b++) bits.push_back(!(b == 0 && f_frm));
    foreach (bits[k])
      for (int c = 0; c < cfg_cpb[i]; c++) exp_bits.push_back(bits[k]);
  endfunction

  task automatic drive(input int i, input logic [7:0] d, input bit a, input bit b);
    if (i == 0) d0 = d;
    else if (i == 1) d1 = d;
    else d2 = d[6:0];
    fp[i] = a;
    fe[i] = b;
  endtask

  task automatic push1(input int i, input logic [7:0] d, input bit a, input bit b);
    drive(i, d, a, b);
    valid[i] = 1'b1;
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  task automatic expect_line(input int i, input int from, input string tag);
    for (int n = from; n < exp_bits.size(); n++) begin
      @(negedge clk);
      check(tag, 32'(tx[i]), 32'(exp_bits[n]));
    end
  endtask

  task automatic send_one(input int i, input logic [7:0] d, input bit a, input bit b);
    exp_bits.delete();
    add_frame(i, d, a, b);
    push1(i, d, a, b);
    check("busy_queued", 32'(busy[i]), 32'd1);
    expect_line(i, 0, "tx_frame");
    exp_cnt[i]++;
    @(negedge clk);
    check("tx_after", 32'(tx[i]), 32'd1);
    check("busy_after", 32'(busy[i]), 32'd0);
    check("sent_count", sent[i], 32'(exp_cnt[i]));
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] rb[3];
    bit ra, rf;
    int mlev;

    nrst = 1'b0; en = '0; valid = '0; fp = '0; fe = '0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_tx", 32'(tx[i]), 32'd1);
      check("rst_ready", 32'(ready[i]), 32'd1);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_level", 32'(level[i]), 32'd0);
      check("rst_sent", sent[i], 32'd0);
    end
    nrst = 1'b1;
    en = 3'b111;
    @(negedge clk);

    // Directed frames from the plan
    send_one(0, 8'h55, 1'b0, 1'b0);
    send_one(0, 8'h07, 1'b1, 1'b0);
    send_one(1, 8'h07, 1'b0, 1'b0);
    send_one(0, 8'hA5, 1'b0, 1'b1);
    send_one(2, 8'h41, 1'b0, 1'b0);

    // Random single frames on every configuration
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 3; i++) begin
        rd = 8'($urandom_range(255));
        ra = 1'($urandom_range(1));
        rf = 1'($urandom_range(1));
        send_one(i, rd, ra, rf);
      end

    // Fill while disabled, then drain back-to-back
    en[0] = 1'b0;
    mlev = 0;
    exp_bits.delete();
    for (int j = 0; j < 17; j++) begin
      rd = 8'($urandom_range(255));
      ra = 1'($urandom_range(1));
      rf = 1'($urandom_range(1));
      check("in_ready_fill", 32'(ready[0]), 32'(mlev < 16));
      drive(0, rd, ra, rf);
      valid[0] = 1'b1;
      @(negedge clk);
      if (mlev < 16) begin
        add_frame(0, rd, ra, rf);
        mlev++;
      end
    end
    valid[0] = 1'b0;
    check("full_level", 32'(level[0]), 32'd16);
    check("full_ready", 32'(ready[0]), 32'd0);
    check("full_tx", 32'(tx[0]), 32'd1);
    check("full_busy", 32'(busy[0]), 32'd1);
    check("full_sent", sent[0], 32'(exp_cnt[0]));
    en[0] = 1'b1;
    expect_line(0, 0, "tx_b2b");
    exp_cnt[0] += 16;
    @(negedge clk);
    check("b2b_sent", sent[0], 32'(exp_cnt[0]));
    check("b2b_busy", 32'(busy[0]), 32'd0);
    check("b2b_level", 32'(level[0]), 32'd0);

    // Reset ten cycles into the data bits with bytes still queued
    exp_bits.delete();
    for (int j = 0; j < 3; j++) rb[j] = 8'($urandom_range(255));
    add_frame(0, rb[0], 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) push1(0, rb[j], 1'b0, 1'b0);
    for (int n = 2; n <= 16; n++) begin
      @(negedge clk);
      check("tx_pre_reset", 32'(tx[0]), 32'(exp_bits[n]));
    end
    check("tx_data_bit3", 32'(tx[0]), 32'(rb[0][3]));
    nrst = 1'b0;
    #1;
    exp_cnt = '{0, 0, 0};
    check("mid_rst_tx", 32'(tx[0]), 32'd1);
    check("mid_rst_level", 32'(level[0]), 32'd0);
    check("mid_rst_sent", sent[0], 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_ready", 32'(ready[0]), 32'd1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      check("tx_post_reset", 32'(tx[0]), 32'd1);
    end
    check("post_rst_busy", 32'(busy[0]), 32'd0);
    check("post_rst_sent", sent[0], 32'd0);
    send_one(0, 8'($urandom_range(255)), 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
